// File: rtl/alu_pkg.sv
// Shared ALU op codes and arbiter state encoding for the ALU-sharing datapath.
package alu_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_OR  = 2'b10;
  localparam logic [OP_W-1:0] OP_BAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the requester named by prio.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && (!valid1 || !prio)) begin
      grant[0] = 1'b1;
    end else if (valid1) begin
      grant[1] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two requesters: capture one request, run it for one cycle,
// then hold the registered result on a valid/ready response tagged with the owner's id.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err
);

  state_t     state;
  logic       prio;
  logic       owner;
  logic [1:0] grant;
  logic       accept_c;

  rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .prio   (prio),
    .grant  (grant)
  );

  // Ready is only offered from IDLE and never while reset is being asserted.
  assign accept_c   = reset && (state == S_IDLE);
  assign req0_ready = accept_c && grant[0];
  assign req1_ready = accept_c && grant[1];

  assign rsp_valid  = (state == S_RESP);
  assign rsp_id     = owner;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant[0] || grant[1]) begin
            owner  <= grant[1];
            alu_a  <= grant[1] ? req1_a  : req0_a;
            alu_b  <= grant[1] ? req1_b  : req0_b;
            alu_op <= grant[1] ? req1_op : req0_op;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          // The unsupported op never trusts whatever the ALU produces.
          if (alu_op == OP_BAD) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            prio  <= ~owner;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
